// File: rtl/subtractor_sequencer_if.sv
// -----------------------------------------------------------------------------
// subtractor_sequencer_if
//   Handshake and data bundle for the multi-cycle nibble-serial subtractor.
//   Signals:
//     start  : request a subtraction (master -> slave)
//     A, B   : minuend / subtrahend, WIDTH bits (master -> slave)
//     busy   : operation in flight, high in RUN and DONE (slave -> master)
//     done   : one-cycle result-valid pulse (slave -> master)
//     Diff   : registered result A - B mod 2^WIDTH (slave -> master)
//     Bout   : final unsigned borrow, 1 when A < B (slave -> master)
//     Zero   : Diff == 0, registered with Diff (slave -> master)
// -----------------------------------------------------------------------------
interface subtractor_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Zero;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Bout, Zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bout, Zero
  );
endinterface

// File: rtl/subtractor_sequencer.sv
// -----------------------------------------------------------------------------
// subtractor_sequencer
//   Unsigned WIDTH-bit subtractor (Diff = A - B) built from one 4-bit
//   borrow-ripple slice of four full_subtractor cells, reused once per nibble,
//   least significant nibble first. The borrow between nibbles is registered.
//   WIDTH must be a multiple of 4 and at least 4.
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous, active-high reset
//     s   : subtractor_sequencer_if.slave (start/A/B in, busy/done/Diff/Bout/Zero out)
// -----------------------------------------------------------------------------

// Single-bit full subtractor: o_d = i_a - i_b - i_bin, o_bout = borrow out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module subtractor_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  subtractor_sequencer_if.slave s
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  // Current nibble selection: bit offset 4*k formed by appending two zeros.
  logic [CW+1:0]    w_shamt;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice;
  logic             w_b1, w_b2, w_b3, w_b4;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_last;

  assign w_shamt = {r_cnt, 2'b00};
  assign w_a_nib = 4'(r_a >> w_shamt);
  assign w_b_nib = 4'(r_b >> w_shamt);

  // Borrow ripple through the four cells; the chain is unrolled so each link
  // is its own net.
  full_subtractor u_fs0 (.i_a(w_a_nib[0]), .i_b(w_b_nib[0]), .i_bin(r_borrow),
                         .o_d(w_slice[0]), .o_bout(w_b1));
  full_subtractor u_fs1 (.i_a(w_a_nib[1]), .i_b(w_b_nib[1]), .i_bin(w_b1),
                         .o_d(w_slice[1]), .o_bout(w_b2));
  full_subtractor u_fs2 (.i_a(w_a_nib[2]), .i_b(w_b_nib[2]), .i_bin(w_b2),
                         .o_d(w_slice[2]), .o_bout(w_b3));
  full_subtractor u_fs3 (.i_a(w_a_nib[3]), .i_b(w_b_nib[3]), .i_bin(w_b3),
                         .o_d(w_slice[3]), .o_bout(w_b4));

  // Diff with nibble k replaced by the slice result; Zero is taken from this
  // full value so it matches Diff on the done edge.
  assign w_mask      = WIDTH'(4'hF) << w_shamt;
  assign w_diff_next = (r_diff & ~w_mask) | (WIDTH'(w_slice) << w_shamt);
  assign w_last      = (r_cnt == CW'(NIB - 1));

  // NOTE: every piece of state, including the operand and result registers,
  // is reset; all are plain flops and reset is cheap insurance against X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      unique case (r_state)
        ST_IDLE: begin
          if (s.start) begin
            r_a      <= s.A;
            r_b      <= s.B;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_diff   <= w_diff_next;
          r_borrow <= w_b4;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_bout  <= w_b4;
            r_zero  <= (w_diff_next == '0);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here: requests are not queued.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s.busy = r_busy;
  assign s.done = r_done;
  assign s.Diff = r_diff;
  assign s.Bout = r_bout;
  assign s.Zero = r_zero;
endmodule

// File: tb/tb_subtractor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_subtractor_sequencer
//   Self-checking bench for subtractor_sequencer (WIDTH = 16). The reference
//   is plain modular arithmetic: Diff = (A - B) mod 2^16, Bout = (A < B),
//   Zero = (Diff == 0), with latency and handshake timing as whole numbers.
// -----------------------------------------------------------------------------
module tb_subtractor_sequencer;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: Bout/Zero hold from the last completed operation.
  logic m_bout = 1'b0;
  logic m_zero = 1'b0;

  subtractor_sequencer_if #(.WIDTH(WIDTH)) bus ();

  subtractor_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation with handshake checks. With disturb set, start is
  // pulsed together with a different A during RUN; it must be ignored.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit disturb);
    logic [15:0] exp_diff;
    int cyc;
    int stray;
    exp_diff = a - b;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);             // accepting edge (edge 0)
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 16'($urandom);  // operands must no longer matter
    bus.B     = 16'($urandom);
    check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    check("done_after_accept", {31'b0, bus.done}, 32'd0);
    check("diff_cleared",      {16'b0, bus.Diff}, 32'd0);
    check("bout_held",         {31'b0, bus.Bout}, {31'b0, m_bout});
    check("zero_held",         {31'b0, bus.Zero}, {31'b0, m_zero});
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (disturb && cyc == 1) begin
        bus.A     = 16'hFFFF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    m_bout = (a < b);
    m_zero = (exp_diff == 16'h0);
    check("latency",       cyc,                    NIB);
    check("diff",          {16'b0, bus.Diff},      {16'b0, exp_diff});
    check("bout",          {31'b0, bus.Bout},      {31'b0, m_bout});
    check("zero",          {31'b0, bus.Zero},      {31'b0, m_zero});
    check("busy_at_done",  {31'b0, bus.busy},      32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'b0, bus.done},     32'd0);
    check("busy_released",  {31'b0, bus.busy},     32'd0);
    if (disturb) begin
      stray = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.busy === 1'b1 || bus.done === 1'b1) stray++;
      end
      check("no_second_op", stray, 0);
    end
  endtask

  initial begin
    int t;
    int last;
    int nd;
    logic [15:0] ra, rb;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b0;
    #1 rst    = 1'b1;
    #2;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_diff", {16'b0, bus.Diff}, 32'd0);
    check("rst_bout", {31'b0, bus.Bout}, 32'd0);
    check("rst_zero", {31'b0, bus.Zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic and borrow-ripple cases
    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    // Zero result and max case
    run_op(16'hBEEF, 16'hBEEF, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b0);
    // Operand isolation and ignored start during RUN
    run_op(16'h0005, 16'h0003, 1'b1);

    // start held high: one operation every NIB+2 cycles
    @(negedge clk);
    bus.A     = 16'h0010;
    bus.B     = 16'h0001;
    bus.start = 1'b1;
    t = 0; last = -1; nd = 0;
    while (nd < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (bus.done === 1'b1) begin
        check("held_diff", {16'b0, bus.Diff}, 32'h000F);
        if (last >= 0) check("held_period", t - last, NIB + 2);
        last = t;
        nd++;
      end
    end
    check("held_done_count", nd, 3);
    bus.start = 1'b0;
    m_bout = 1'b0;
    m_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held_idle", {31'b0, bus.busy}, 32'd0);

    // Reset in the middle of RUN, after a borrow-producing op sets Bout
    run_op(16'h0000, 16'h0001, 1'b0);
    @(negedge clk);
    bus.A     = 16'h4321;
    bus.B     = 16'h1111;
    bus.start = 1'b1;
    @(posedge clk);             // accept
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);             // first RUN edge
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrun_rst_done", {31'b0, bus.done}, 32'd0);
    check("midrun_rst_diff", {16'b0, bus.Diff}, 32'd0);
    check("midrun_rst_bout", {31'b0, bus.Bout}, 32'd0);
    check("midrun_rst_zero", {31'b0, bus.Zero}, 32'd0);
    m_bout = 1'b0;
    m_zero = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0777, 16'h0123, 1'b0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 0) rb = ra;  // exercise Zero regularly
      run_op(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/subtractor_sequencer.md
Name: subtractor_sequencer

Overview:
Multi-precision unsigned subtractor that computes Diff = A - B for WIDTH-bit operands. It reuses a single 4-bit borrow-ripple slice, made of four full_subtractor cells, over WIDTH/4 clock cycles, one nibble per cycle, least significant nibble first. A registered borrow is carried between nibbles. It provides a start/busy/done handshake so ALU-level control can sequence wide subtractions on the narrow datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, number of nibble iterations; derived, not overridable.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a subtraction; sampled only in IDLE.
A  input  WIDTH  minuend; captured on the accepting edge.
B  input  WIDTH  subtrahend; captured on the accepting edge.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result valid.
Diff  output  WIDTH  registered result, held until the next accept.
Bout  output  1  final borrow; 1 when A < B (unsigned).
Zero  output  1  high when Diff == 0; registered with Diff.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, and is named rst as in the rest of the codebase.
- Reset (asynchronous, any state including mid-RUN): state=IDLE; busy=0, done=0, Diff=0, Bout=0, Zero=0; nibble counter=0, borrow flop=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start=1 on an edge: capture A and B into internal registers, clear Diff to 0, clear the borrow flop, set counter=0, and go to RUN.
  - When start=0: remain in IDLE; outputs hold their values.
- RUN:
  - Each edge computes slice = A_reg[4k+3:4k] - B_reg[4k+3:4k] - borrow, where k = counter.
  - Writes Diff[4k+3:4k] and the borrow flop, then increments the counter.
  - When k = NIB-1: load Bout from the slice borrow-out, load Zero from the full next Diff value, set done=1, go to DONE.
- DONE: lasts exactly one cycle. On the next edge: done=0, go to IDLE.
- start is ignored in RUN and DONE; it is not queued.
- Latency: with the accepting edge as edge 0, nibble k is written at edge k+1 and done rises at edge NIB, with busy high from edge 0 to edge NIB+1.
  - Back-to-back issue with start held high gives one operation per NIB+2 cycles.
- A and B may change freely after the accepting edge; they do not affect the result.
- Diff is undefined for the user while busy (partial nibbles are visible). It is valid from the done edge until the next accept.
- Arithmetic is modulo 2^WIDTH. Bout follows unsigned borrow semantics; there is no signed overflow flag.
- Bout and Zero update only at the done edge and hold until the next done or reset. They are not cleared on accept.
- A start edge coincident with deasserting rst: rst dominates while asserted; start is first sampled on the first edge after release.

Test Plan:
- Reset, then WIDTH=16, A=0x1234, B=0x0234, start for 1 cycle -> busy=1 next cycle; done=1 exactly 4 cycles after accept; Diff=0x1000, Bout=0, Zero=0; busy=0 two cycles after accept+4.
- Borrow ripple across all nibbles: A=0x1000, B=0x0001 -> Diff=0x0FFF, Bout=0. Then A=0x0000, B=0x0001 -> Diff=0xFFFF, Bout=1.
- Zero result: A=B=0xBEEF -> Diff=0x0000, Zero=1, Bout=0. Max case: A=0xFFFF, B=0x0000 -> Diff=0xFFFF.
- Operand isolation and ignored start: accept A=0x0005, B=0x0003; pulse start with A=0xFFFF during RUN -> single done, Diff=0x0002; no second operation begins.
- start held high continuously with A=0x0010, B=0x0001 -> done pulses every 6 cycles, each with Diff=0x000F.
- Assert rst at the 2nd RUN cycle -> immediately state IDLE, busy=0, done=0, Diff=0, Bout=0. A fresh start after release completes normally with the correct result.
